// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word reads to instruction memory and
// buffers {pc, instr} pairs in a small FIFO for decode; redirect flushes and restarts.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] fetch_pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_pc_mem  [FIFO_DEPTH];
  logic [31:0]   r_ins_mem [FIFO_DEPTH];
  logic          w_push;
  logic          w_pop;
  logic          w_unused_lsb;

  assign w_unused_lsb = ^redirect_pc[1:0];

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_fetch_pc;
  assign fetch_pc  = r_fetch_pc;
  assign out_valid = (r_count != '0);
  assign out_pc    = r_pc_mem[r_rd_ptr];
  assign out_instr = r_ins_mem[r_rd_ptr];

  // A response landing in the redirect cycle belongs to the old stream and is dropped.
  assign w_push = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign w_pop  = out_valid && out_ready;

  assign w_count_nxt = redirect_valid ? '0
                     : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count < DEPTH_C) w_state_nxt = S_REQ;
      S_REQ:   if (imem_gnt) w_state_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid) w_state_nxt = (w_count_nxt < DEPTH_C) ? S_REQ : S_IDLE;
      S_DRAIN: if (imem_rvalid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
    // In DRAIN the orphan is still owed, so a redirect only moves fetch_pc there.
    if (redirect_valid && r_state != S_DRAIN) begin
      case (r_state)
        S_REQ:   w_state_nxt = imem_gnt ? S_DRAIN : S_REQ;
        S_WAIT:  w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_pc_mem[i]  <= '0;
        r_ins_mem[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (redirect_valid)
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (w_push)
        r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push) begin
        r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
        r_ins_mem[r_wr_ptr] <= imem_rdata;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (redirect_valid)
        r_rd_ptr <= r_wr_ptr;
      else if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory returns addr ^ KEY; a second
// instance with RESET_PC = FFFF_FFFC runs against a zero-wait memory for wrap-around.
module tb_instr_fetch_unit;
  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, fetch_pc;

  logic        w2_req, w2_gnt, w2_rvalid, w2_out_valid;
  logic [31:0] w2_addr, w2_rdata, w2_out_pc, w2_out_instr, w2_fetch_pc;

  logic [31:0] q[$];
  bit          gnt_en, rv_en;
  logic [31:0] g_addr;
  logic        g2;
  logic [31:0] a2;
  logic [31:0] exp_pc;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  assign w2_gnt = w2_req;

  instr_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .fetch_pc(fetch_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w2_req), .imem_addr(w2_addr), .imem_gnt(w2_gnt),
    .imem_rvalid(w2_rvalid), .imem_rdata(w2_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w2_out_valid), .out_ready(1'b1),
    .out_pc(w2_out_pc), .out_instr(w2_out_instr), .fetch_pc(w2_fetch_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_drive();
    imem_gnt    = gnt_en && imem_req;
    g_addr      = imem_addr;
    imem_rvalid = rv_en && (q.size() > 0);
    imem_rdata  = imem_rvalid ? (q[0] ^ KEY) : 32'h0;
  endtask

  task automatic cyc();
    g2 = w2_req;
    a2 = w2_addr;
    @(posedge clk); #1;
    if (imem_rvalid) void'(q.pop_front());
    if (imem_gnt) q.push_back(g_addr);
    w2_rvalid = g2 && rst_n;
    w2_rdata  = a2 ^ KEY;
    mem_drive();
  endtask

  task automatic do_reset(input bit rdy);
    rst_n = 1'b0; #1;
    gnt_en = 1; rv_en = 1;
    q.delete();
    redirect_valid = 0; redirect_pc = 0;
    out_ready = rdy;
    w2_rvalid = 0; w2_rdata = 0;
    mem_drive();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_wrap_addr", w2_addr, 32'hFFFF_FFFC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Start-up and zero-wait streaming
    do_reset(1);
    cyc();
    chk("start_req", imem_req, 1);
    chk("start_addr", imem_addr, 32'h0);
    chk("start_valid_e1", out_valid, 0);
    cyc();
    chk("start_valid_e2", out_valid, 0);
    chk("start_req_wait", imem_req, 0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'(4 * k);
      chk("seq_valid", out_valid, 1);
      chk("seq_pc", out_pc, exp_pc);
      chk("seq_instr", out_instr, exp_pc ^ KEY);
      exp_pc = 32'hFFFF_FFFC + 32'(4 * k);
      chk("wrap_valid", w2_out_valid, 1);
      chk("wrap_pc", w2_out_pc, exp_pc);
      chk("wrap_instr", w2_out_instr, exp_pc ^ KEY);
      cyc();
      chk("seq_gap", out_valid, 0);
      cyc();
    end

    // Backpressure: reset lands mid-stream
    do_reset(0);
    repeat (5) cyc();
    repeat (3) begin
      cyc();
      chk("bp_req_idle", imem_req, 0);
    end
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_pc, 32'h0);
    chk("bp_fetch_pc", fetch_pc, 32'h8);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("bp_pop_head", out_pc, 32'h4);
    chk("bp_pop_req", imem_req, 0);
    cyc();
    chk("bp_next_req", imem_req, 1);
    chk("bp_next_addr", imem_addr, 32'h8);

    // Grant stall
    do_reset(1);
    gnt_en = 0;
    cyc();
    repeat (5) begin
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, 32'h0);
      cyc();
    end
    gnt_en = 1;
    mem_drive();
    cyc();
    chk("stall_granted", imem_req, 0);
    cyc();
    chk("stall_valid", out_valid, 1);
    chk("stall_pc", out_pc, 32'h0);
    chk("stall_instr", out_instr, KEY);

    // Redirect while a response is outstanding
    do_reset(1);
    repeat (5) cyc();
    rv_en = 0;
    cyc();
    chk("rw_wait_req", imem_req, 0);
    chk("rw_wait_fpc", fetch_pc, 32'h8);
    chk("rw_wait_valid", out_valid, 0);
    redirect_valid = 1; redirect_pc = 32'h0000_0103;
    cyc();
    redirect_valid = 0;
    chk("rw_fpc", fetch_pc, 32'h100);
    chk("rw_req", imem_req, 0);
    chk("rw_valid", out_valid, 0);
    cyc(); cyc();
    chk("rw_drain_req", imem_req, 0);
    rv_en = 1;
    mem_drive();
    cyc();
    chk("rw_discard_valid", out_valid, 0);
    chk("rw_new_req", imem_req, 1);
    chk("rw_new_addr", imem_addr, 32'h100);
    cyc(); cyc();
    chk("rw_out_valid", out_valid, 1);
    chk("rw_out_pc", out_pc, 32'h100);
    chk("rw_out_instr", out_instr, 32'h100 ^ KEY);

    // Redirect coinciding with pop and response
    do_reset(0);
    repeat (4) cyc();
    chk("rpr_pre_valid", out_valid, 1);
    chk("rpr_pre_pc", out_pc, 32'h0);
    chk("rpr_pre_rvalid", imem_rvalid, 1);
    out_ready = 1;
    redirect_valid = 1; redirect_pc = 32'h0000_0200;
    cyc();
    redirect_valid = 0;
    chk("rpr_flushed", out_valid, 0);
    chk("rpr_req", imem_req, 1);
    chk("rpr_addr", imem_addr, 32'h200);
    cyc(); cyc();
    chk("rpr_out_valid", out_valid, 1);
    chk("rpr_out_pc", out_pc, 32'h200);
    chk("rpr_out_instr", out_instr, 32'h200 ^ KEY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
